// File: rtl/mat_acc_driver.sv
// Host-side sequencer for the matrix accelerator: streams in A and B,
// pulses start, waits for done and streams C back out.
module mat_acc_driver #(
  parameter int MAT_SIZE    = 2,
  parameter int DAT_SIZE    = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic [DAT_SIZE-1:0] in_data,
  output logic in_ready,
  output logic out_valid,
  output logic [DAT_SIZE-1:0] out_data,
  input  logic out_ready,
  output logic [MAT_SIZE-1:0][MAT_SIZE-1:0][DAT_SIZE-1:0] mat_A,
  output logic [MAT_SIZE-1:0][MAT_SIZE-1:0][DAT_SIZE-1:0] mat_B,
  output logic start,
  input  logic done,
  input  logic [MAT_SIZE-1:0][MAT_SIZE-1:0][DAT_SIZE-1:0] mat_C,
  output logic busy,
  output logic timeout
);

  localparam int NN = MAT_SIZE * MAT_SIZE;
  localparam int IW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [IW-1:0] LAST = IW'(NN - 1);
  localparam logic [15:0] TMO = 16'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    START,
    WAIT,
    DRAIN
  } state_t;

  state_t state;
  logic [IW-1:0] idx;
  logic [15:0] tcnt;

  // Flat row-major storage: element r*N+c lines up with packed [r][c].
  logic [NN-1:0][DAT_SIZE-1:0] a_q;
  logic [NN-1:0][DAT_SIZE-1:0] b_q;
  logic [NN-1:0][DAT_SIZE-1:0] c_q;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign mat_A    = a_q;
  assign mat_B    = b_q;
  assign out_data = c_q[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD_A;
      idx       <= '0;
      tcnt      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      start     <= 1'b0;
      out_valid <= 1'b0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      start <= 1'b0;
      unique case (state)
        LOAD_A: begin
          if (in_xfer) begin
            a_q[idx] <= in_data;
            timeout  <= 1'b0;
            busy     <= 1'b1;
            if (idx == LAST) begin
              idx   <= '0;
              state <= LOAD_B;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        LOAD_B: begin
          if (in_xfer) begin
            b_q[idx] <= in_data;
            if (idx == LAST) begin
              idx      <= '0;
              in_ready <= 1'b0;
              start    <= 1'b1;
              state    <= START;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        START: begin
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // done has priority over an expiring count
          if (done) begin
            c_q       <= mat_C;
            out_valid <= 1'b1;
            state     <= DRAIN;
          end else if (tcnt + 16'd1 == TMO) begin
            timeout  <= 1'b1;
            idx      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= LOAD_A;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        DRAIN: begin
          if (out_xfer) begin
            if (idx == LAST) begin
              out_valid <= 1'b0;
              idx       <= '0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
              state     <= LOAD_A;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        default: begin
          state <= LOAD_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mat_acc_driver.sv
// Scoreboard bench for mat_acc_driver with a behavioural accelerator
// model and a matrix-product reference computed from the stimulus.
module tb_mat_acc_driver;

  typedef logic [7:0] mat_t [4];

  logic clk;
  logic rst_n;
  logic in_valid;
  logic [7:0] in_data;
  logic in_ready;
  logic out_valid;
  logic [7:0] out_data;
  logic out_ready;
  logic [1:0][1:0][7:0] mat_A;
  logic [1:0][1:0][7:0] mat_B;
  logic start;
  logic done;
  logic [1:0][1:0][7:0] mat_C;
  logic busy;
  logic timeout;

  mat_acc_driver #(
    .MAT_SIZE(2),
    .DAT_SIZE(8),
    .TIMEOUT_CYC(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .mat_A(mat_A),
    .mat_B(mat_B),
    .start(start),
    .done(done),
    .mat_C(mat_C),
    .busy(busy),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  int n_out = 0;
  int n_start = 0;
  int first_xfer_nout = 0;
  int acc_mode = 0;
  int acc_delay = 3;
  int rdy_mode = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic expire(input string nm);
    checks++;
    fails++;
    $display("FAIL %s wait bound expired", nm);
  endtask

  function automatic void push_exp(input mat_t a, input mat_t b);
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < 2; k++)
          s += int'(a[i*2+k]) * int'(b[k*2+j]);
        exp_q.push_back(8'(s));
      end
    end
  endfunction

  // Accelerator model: product computed on the start edge, done later.
  initial begin
    logic s;
    logic [1:0][1:0][7:0] ma;
    logic [1:0][1:0][7:0] mb;
    int cnt;
    bit pend;
    done = 1'b0;
    mat_C = '0;
    cnt = 0;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      s = start;
      ma = mat_A;
      mb = mat_B;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        done = 1'b0;
        pend = 1'b0;
      end else if (s) begin
        for (int i = 0; i < 2; i++)
          for (int j = 0; j < 2; j++)
            mat_C[i][j] = 8'(int'(ma[i][0]) * int'(mb[0][j])
                           + int'(ma[i][1]) * int'(mb[1][j]));
        cnt = acc_delay;
        pend = (acc_mode == 0);
        done = (acc_mode == 2);
      end else if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          done = 1'b1;
          pend = 1'b0;
        end
      end
      if (acc_mode == 2) done = 1'b1;
    end
  end

  initial begin
    bit t;
    t = 1'b0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      t = ~t;
      case (rdy_mode)
        1: out_ready = t;
        2: out_ready = 1'($urandom % 2);
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor / scoreboard
  logic prev_stall = 1'b0;
  logic prev_start = 1'b0;
  logic [7:0] prev_data = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (start) begin
        n_start++;
        chk("start_one_cycle", 64'(prev_start), 64'(0));
      end
      prev_start = start;
      if (prev_stall) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_data", 64'(out_data), 64'(prev_data));
      end
      if (out_valid) begin
        chk("busy_in_drain", 64'(busy), 64'(1));
        chk("in_ready_in_drain", 64'(in_ready), 64'(0));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 64'(out_valid), 64'(0));
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(e));
        end
        n_out++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic load_op(input mat_t a, input mat_t b, input int gap,
                         input bit push);
    if (push) push_exp(a, b);
    for (int e = 0; e < 8; e++) begin
      int guard;
      in_valid = 1'b1;
      in_data = (e < 4) ? a[e] : b[e-4];
      guard = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        guard++;
        if (guard > 2000) begin
          expire("load_stall");
          in_valid = 1'b0;
          return;
        end
      end
      if (e == 0) first_xfer_nout = n_out;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (gap != 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
      guard++;
      if (guard > 3000) begin
        expire("wait_idle");
        exp_q.delete();
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start();
    int guard;
    guard = 0;
    forever begin
      @(negedge clk);
      if (start) break;
      guard++;
      if (guard > 200) begin
        expire("wait_start");
        break;
      end
    end
  endtask

  function automatic mat_t rnd_mat();
    mat_t m;
    for (int i = 0; i < 4; i++) m[i] = 8'($urandom);
    return m;
  endfunction

  initial begin
    mat_t a1;
    mat_t b1;
    mat_t id;
    int base;
    int s0;
    int guard;
    a1 = '{8'd1, 8'd2, 8'd3, 8'd4};
    b1 = '{8'd5, 8'd6, 8'd7, 8'd8};
    id = '{8'd1, 8'd0, 8'd0, 8'd1};
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_start", 64'(start), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_timeout", 64'(timeout), 64'(0));
    chk("rst_mat_A", 64'(mat_A), 64'(0));
    chk("rst_mat_B", 64'(mat_B), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    chk("post_rst_busy", 64'(busy), 64'(0));

    // Basic op: 19,22,43,50
    acc_mode = 0;
    acc_delay = 3;
    s0 = n_start;
    load_op(a1, b1, 0, 1'b1);
    chk("busy_after_load", 64'(busy), 64'(1));
    wait_idle();
    chk("one_start", 64'(n_start - s0), 64'(1));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_in_ready", 64'(in_ready), 64'(1));

    // Input gaps and output stalls
    rdy_mode = 1;
    load_op(a1, b1, 1, 1'b1);
    wait_idle();
    rdy_mode = 0;

    // Timeout: done never rises
    acc_mode = 1;
    load_op(rnd_mat(), rnd_mat(), 0, 1'b0);
    wait_start();
    for (int m = 1; m <= 11; m++) begin
      @(negedge clk);
      chk("to_no_out", 64'(out_valid), 64'(0));
      if (m == 10) chk("to_early", 64'(timeout), 64'(0));
      if (m == 11) begin
        chk("to_set", 64'(timeout), 64'(1));
        chk("to_in_ready", 64'(in_ready), 64'(1));
        chk("to_busy", 64'(busy), 64'(0));
      end
    end
    @(posedge clk);
    #1;
    chk("to_sticky", 64'(timeout), 64'(1));
    acc_mode = 0;
    load_op(a1, b1, 0, 1'b1);
    chk("to_cleared", 64'(timeout), 64'(0));
    wait_idle();

    // done held high: DRAIN right after the first WAIT cycle
    acc_mode = 2;
    load_op(rnd_mat(), rnd_mat(), 0, 1'b1);
    wait_start();
    @(negedge clk);
    chk("wait_first_cycle", 64'(out_valid), 64'(0));
    @(negedge clk);
    chk("drain_entry", 64'(out_valid), 64'(1));
    wait_idle();
    acc_mode = 0;

    // Reset after 3 of 4 outputs
    base = n_out;
    load_op(rnd_mat(), rnd_mat(), 0, 1'b1);
    guard = 0;
    forever begin
      @(posedge clk);
      if (n_out >= base + 3) break;
      guard++;
      if (guard > 500) begin
        expire("wait_three_out");
        break;
      end
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_out_data", 64'(out_data), 64'(0));
    chk("mid_rst_mat_A", 64'(mat_A), 64'(0));
    chk("mid_rst_mat_B", 64'(mat_B), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    load_op(id, id, 0, 1'b1);
    wait_idle();

    // Back-to-back loads
    base = n_out;
    load_op(a1, b1, 0, 1'b1);
    load_op(b1, a1, 0, 1'b1);
    chk("b2b_stalled", 64'(first_xfer_nout - base), 64'(4));
    wait_idle();

    // Randomised operations
    rdy_mode = 2;
    for (int r = 0; r < 12; r++) begin
      acc_delay = $urandom_range(1, 6);
      load_op(rnd_mat(), rnd_mat(), int'($urandom % 2), 1'b1);
      if (r % 3 != 2) wait_idle();
    end
    wait_idle();
    rdy_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
